wrap_iram_ldr: RTL
==================

Name: wrap_iram_ldr

Overview:
- Parametrised instruction-RAM wrapper with a core fetch port and a loader (boot/debug) write port on one single-port array.
- Adds behaviour the fixed-size wrapper lacks:
  - post-reset memory clear sequencer;
  - loader byte-enable writes with req/ack handshake;
  - fetch/loader arbitration with stall;
  - registered read-valid;
  - out-of-range detection.
- Sits between the core instruction-fetch interface and the boot loader. The array is an inferred behavioural memory inside the block.

Parameters:
- AW, 12, word-address width; DEPTH = 2**AW words.
- DW, 32, data width; must be a multiple of 8; NB = DW/8 byte lanes.
- CLR_ON_RST, 1, 1 = zero the whole array after reset; 0 = skip clear.
- ILL_WORD, 32'h0000_0013, data returned for out-of-range fetches (RV32 NOP).

Ports:
- sclk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- mem_rd  in  1  fetch request; held until accepted.
- addr  in  32  fetch byte address; word index = addr[AW+1:2].
- fetch_rdy  out  1  fetch accepted this cycle when mem_rd & fetch_rdy.
- rdata  out  DW  fetch read data.
- rvalid  out  1  one-cycle pulse, rdata valid.
- rerr  out  1  pulse with rvalid when the fetch was out of range.
- ld_req  in  1  loader write request; ld_* fields held until ld_ack.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  DW  loader write data.
- ld_be  in  NB  loader byte enables.
- ld_ack  out  1  one-cycle pulse, loader write committed.
- busy  out  1  high while clearing.

Behaviour:
- Reset (rstn low, async):
  - rdata = 0, rvalid = 0, rerr = 0, ld_ack = 0, fetch_rdy = 0.
  - busy = CLR_ON_RST; clear counter = 0.
  - State = CLEAR if CLR_ON_RST, else IDLE.
  - Array contents are not reset.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Writes 0 to word clr_cnt each cycle; clr_cnt increments 0..DEPTH-1.
  - After writing DEPTH-1, goes to IDLE next cycle; busy falls in the same edge.
  - Clear takes exactly DEPTH cycles after reset release.
  - fetch_rdy = 0 and ld_ack = 0 throughout; requests are ignored but remain pending.
- IDLE arbitration, one array access per cycle, loader has priority:
  - ld_req = 1: write, ld_ack pulses the next cycle, fetch_rdy = 0 this cycle.
  - ld_req = 0: fetch_rdy = 1 (combinational from state and ld_req).
- Loader write:
  - Byte lane i written only if ld_be[i]; ld_be = 0 still acks with no change.
  - Out-of-range write (ld_addr[31:AW+2] != 0): no array change, still acked.
  - ld_req sampled the cycle after ld_ack is treated as a new request. The loader must drop ld_req in the ack cycle or present the next word.
- Fetch:
  - Accepted at edge N; rvalid = 1 and rdata valid at N+1 (latency 1).
  - rdata holds its value until the next accepted fetch.
  - Back-to-back fetches give one rvalid per accepted cycle.
- Out-of-range fetch (addr[31:AW+2] != 0): array not accessed; at N+1 rdata = ILL_WORD, rvalid = 1, rerr = 1.
- addr[1:0] and ld_addr[1:0] are ignored (word aligned).
- Read after write to the same word: a fetch accepted the cycle after ld_ack returns the new data. No same-cycle collision is possible.
- Reset asserted mid-clear or mid-access: immediate return to reset values. A clear restarts from 0; an in-flight write may or may not be committed.

Test Plan:
- CLR_ON_RST=1, AW=4: release reset with mem_rd=1, addr=0 -> busy high exactly 16 cycles, fetch_rdy=0 throughout. First accept the cycle busy falls; rvalid next cycle with rdata=0.
- Loader writes 0xDEADBEEF to addr 0x8 with ld_be=4'hF, then ld_wdata=0x11223344 with ld_be=4'b0101 -> each ld_ack is one cycle. Fetch of 0x8 returns 0xDE22BE44 one cycle after accept.
- mem_rd and ld_req asserted together -> fetch_rdy=0 that cycle, write committed and ld_ack pulses. Fetch accepted the following cycle returns the new data; exactly one rvalid.
- Fetch addr=0x0001_0000 with AW=12 -> rvalid=1, rerr=1, rdata=0x00000013. Loader write to the same address is acked, and array word 0 is unchanged.
- Continuous fetches addr 0,4,8,C with ld_req=0 -> four consecutive rvalid pulses, data in order, no bubbles.
- Assert rstn low during CLEAR at clr_cnt=7 -> outputs return to reset values at once. After release, busy is high for the full DEPTH cycles again.

Source files
------------

// File: rtl/wrap_iram_ldr.sv
// wrap_iram_ldr
// Instruction RAM wrapper: one single-port behavioural array shared by the
// core fetch port and a boot/debug loader write port.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | zeroing word r_clr_cnt each cycle after reset; all requests held off
// IDLE  | one access per cycle; a loader write wins over a fetch
//
// Ports
//   sclk, rstn          clock (rising edge) / async active-low reset
//   mem_rd, addr        fetch request and byte address
//   fetch_rdy           fetch accepted when mem_rd & fetch_rdy
//   rdata/rvalid/rerr   registered fetch result, valid pulse, out-of-range flag
//   ld_req/ld_addr/ld_wdata/ld_be   loader write request (held until ld_ack)
//   ld_ack              one-cycle pulse, loader write committed
//   busy                high while the post-reset clear runs
module wrap_iram_ldr #(
   parameter int          AW         = 12,
   parameter int          DW         = 32,
   parameter bit          CLR_ON_RST = 1'b1,
   parameter logic [31:0] ILL_WORD   = 32'h0000_0013,
   localparam int         NB         = DW / 8,
   localparam int         DEPTH      = 2 ** AW
) (
   input  logic          sclk,
   input  logic          rstn,
   input  logic          mem_rd,
   input  logic [31:0]   addr,
   output logic          fetch_rdy,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          rerr,
   input  logic          ld_req,
   input  logic [31:0]   ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic [NB-1:0] ld_be,
   output logic          ld_ack,
   output logic          busy
);

   localparam logic [DW-1:0] W_ILL = DW'(ILL_WORD);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_clr_cnt;
   logic            r_busy;
   logic [DW-1:0]   r_rdata;
   logic            r_rvalid;
   logic            r_rerr;
   logic            r_ld_ack;
   logic [DW-1:0]   r_mem [DEPTH];

   logic            w_idle;
   logic            w_fetch_rdy;
   logic            w_accept;
   logic            w_f_oor;
   logic            w_l_oor;
   logic [AW-1:0]   w_f_idx;
   logic [AW-1:0]   w_l_idx;
   logic            w_we;
   logic [AW-1:0]   w_wa;
   logic [DW-1:0]   w_wd;
   logic [NB-1:0]   w_wbe;
   logic            w_unused;

   // Byte offset bits are don't-care: every access is a whole word.
   assign w_unused = ^{addr[1:0], ld_addr[1:0]};

   assign w_idle  = (r_state == ST_IDLE);
   assign w_f_oor = |addr[31:AW+2];
   assign w_l_oor = |ld_addr[31:AW+2];
   assign w_f_idx = addr[AW+1:2];
   assign w_l_idx = ld_addr[AW+1:2];

   // Gated with rstn so nothing looks accepted while reset is held with
   // CLR_ON_RST = 0 (state already IDLE).
   assign w_fetch_rdy = rstn & w_idle & ~ld_req;
   assign w_accept    = mem_rd & w_fetch_rdy;

   // Single write port shared by the clear sequencer and the loader.
   always_comb begin
      w_we  = 1'b0;
      w_wa  = w_l_idx;
      w_wd  = ld_wdata;
      w_wbe = ld_be;
      if (rstn && r_state == ST_CLEAR) begin
         w_we  = 1'b1;
         w_wa  = r_clr_cnt;
         w_wd  = '0;
         w_wbe = '1;
      end else if (rstn && w_idle && ld_req && !w_l_oor) begin
         w_we = 1'b1;
      end
   end

   always_ff @(posedge sclk) begin
      if (w_we) begin
         for (int i = 0; i < NB; i++) begin
            if (w_wbe[i]) r_mem[w_wa][8*i +: 8] <= w_wd[8*i +: 8];
         end
      end
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
         r_clr_cnt <= '0;
         r_busy    <= CLR_ON_RST;
         r_rdata   <= '0;
         r_rvalid  <= 1'b0;
         r_rerr    <= 1'b0;
         r_ld_ack  <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + AW'(1);
               r_rvalid  <= 1'b0;
               r_rerr    <= 1'b0;
               r_ld_ack  <= 1'b0;
               if (&r_clr_cnt) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_IDLE: begin
               // Ack is unconditional on range: an out-of-range write is dropped
               // silently so the loader never stalls.
               r_ld_ack <= ld_req;
               r_rvalid <= w_accept;
               r_rerr   <= w_accept & w_f_oor;
               if (w_accept) r_rdata <= w_f_oor ? W_ILL : r_mem[w_f_idx];
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fetch_rdy = w_fetch_rdy;
   assign rdata     = r_rdata;
   assign rvalid    = r_rvalid;
   assign rerr      = r_rerr;
   assign ld_ack    = r_ld_ack;
   assign busy      = r_busy;

endmodule
